// File: rtl/frame_rate_buffer.sv
// frame_rate_buffer: double-buffered frame rate switch.
// Captures a frame of sparse in_valid samples into one of two ping-pong banks
// and replays each full bank as a contiguous ready/valid burst with out_last.
// Optional macro FRAME_RATE_BUFFER_DROP_CNT_EN adds a saturating drop counter.
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   point_num        frame length, latched when a request edge is accepted
//   request          rising edge arms capture of one frame
//   in_valid/in_data capture strobe and sample (channel 0 in LSBs)
//   out_data/out_valid/out_ready/out_last  replay stream
//   busy             capture armed or any bank holding/draining a frame
//   overflow         one-cycle pulse when a request edge found no free bank
//   drop_clr/drop_cnt (macro only) overflow pulse counter and its clear
module frame_rate_buffer #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH:0]            point_num,
  input  logic                           request,
  input  logic                           in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           overflow
`ifdef FRAME_RATE_BUFFER_DROP_CNT_EN
  ,
  input  logic                           drop_clr,
  output logic [15:0]                    drop_cnt
`endif
);

  localparam int unsigned W  = CHANNELS * DATA_WIDTH;
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] LOW_MASK = CW'(DEPTH - 1);

  typedef enum logic {W_IDLE = 1'b0, W_CAP = 1'b1} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FILL = 2'd1, R_STREAM = 2'd2} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic               req_dly_q, req_dly_d;
  logic               wbank_q, wbank_d;
  logic               rbank_q, rbank_d;
  logic [1:0]         full_q, full_d;
  logic [CW-1:0]      wr_addr_q, wr_addr_d;
  logic [CW-1:0]      rd_addr_q, rd_addr_d;
  logic [1:0][CW-1:0] blen_q, blen_d;
  logic [W-1:0]       out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;

  logic          rise_c, rel_c, wfree_c, wr_en_c, wr_done_c, load_c;
  logic [CW-1:0] len_c, wlen_c, rlen_c, wr_ra_c, rd_ra_c;

  logic [W-1:0] mem [2*DEPTH];
  logic [W-1:0] ram_rdata_q;

  // Decode request edge, frame length and bank handshakes
  assign rise_c    = request & ~req_dly_q;
  assign len_c     = (point_num == '0 || point_num > DEPTH_C) ? DEPTH_C : point_num;
  assign wlen_c    = blen_q[wbank_q];
  assign rlen_c    = blen_q[rbank_q];
  assign rel_c     = (r_state_q == R_STREAM) & out_valid_q & out_ready & out_last_q;
  // A bank released this cycle may be claimed by a same-cycle request
  assign wfree_c   = ~full_q[wbank_q] | (rel_c & (rbank_q == wbank_q));
  assign wr_en_c   = (w_state_q == W_CAP) & in_valid;
  assign wr_done_c = wr_en_c & (wr_addr_q == wlen_c - CW'(1));
  assign load_c    = ~out_valid_q | out_ready;

  // RAM is addressed with next-cycle read state so its output is ready when needed
  assign wr_ra_c = (CW'(wbank_q) << ADDR_WIDTH) | (wr_addr_q & LOW_MASK);
  assign rd_ra_c = (CW'(rbank_d) << ADDR_WIDTH) | (rd_addr_d & LOW_MASK);

  // Both banks in one array, one write and one registered read port
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ra_c] <= in_data;
    ram_rdata_q <= mem[rd_ra_c];
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Next-state logic for write and read FSMs
  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    case (w_state_q)
      W_IDLE:  if (rise_c && wfree_c) w_state_d = W_CAP;
      W_CAP:   if (wr_done_c) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    case (r_state_q)
      R_IDLE:   if (full_q[rbank_q]) r_state_d = R_FILL;
      R_FILL:   r_state_d = R_STREAM;
      R_STREAM: if (rel_c) r_state_d = full_q[~rbank_q] ? R_FILL : R_IDLE;
      default:  r_state_d = R_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    req_dly_d   = request;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    full_d      = full_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    blen_d      = blen_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overflow_d  = 1'b0;

    if (w_state_q == W_IDLE && rise_c) begin
      if (wfree_c) begin
        wr_addr_d      = '0;
        blen_d[wbank_q] = len_c;
      end else begin
        overflow_d = 1'b1;
      end
    end
    if (wr_en_c) begin
      wr_addr_d = wr_addr_q + CW'(1);
      if (wr_done_c) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end

    // rd_addr_q indexes the sample currently held in ram_rdata_q
    case (r_state_q)
      R_IDLE: rd_addr_d = '0;
      R_FILL: begin
        out_data_d  = ram_rdata_q;
        out_valid_d = 1'b1;
        out_last_d  = (rlen_c == CW'(1));
        rd_addr_d   = CW'(1);
      end
      R_STREAM: begin
        if (rel_c) begin
          out_valid_d     = 1'b0;
          out_last_d      = 1'b0;
          full_d[rbank_q] = 1'b0;
          rbank_d         = ~rbank_q;
          rd_addr_d       = '0;
        end else if (load_c) begin
          out_data_d  = ram_rdata_q;
          out_valid_d = 1'b1;
          out_last_d  = (rd_addr_q == rlen_c - CW'(1));
          rd_addr_d   = rd_addr_q + CW'(1);
        end
      end
      default: ;
    endcase

    busy_d = (w_state_d == W_CAP) | (|full_d);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_dly_q   <= 1'b0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      full_q      <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      blen_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      req_dly_q   <= req_dly_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      full_q      <= full_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      blen_q      <= blen_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

`ifdef FRAME_RATE_BUFFER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating overflow counter; clear wins over a same-cycle increment
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr) drop_cnt_d = '0;
    else if (overflow_d && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_frame_rate_buffer.sv
// Testbench for frame_rate_buffer: randomized frames checked against a
// frame-level reference model (accepted frames replayed in order).
module tb_frame_rate_buffer;
  localparam int unsigned DW    = 12;
  localparam int unsigned CH    = 3;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned W     = CH * DW;
  localparam int unsigned CW    = AW + 1;

  logic clk = 1'b0;
  logic rst, request, in_valid, out_valid, out_ready, out_last, busy, overflow;
  logic [CW-1:0] point_num;
  logic [W-1:0]  in_data, out_data;
`ifdef FRAME_RATE_BUFFER_DROP_CNT_EN
  logic        drop_clr;
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  frame_rate_buffer #(.DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .point_num(point_num), .request(request),
    .in_valid(in_valid), .in_data(in_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .overflow(overflow)
`ifdef FRAME_RATE_BUFFER_DROP_CNT_EN
    , .drop_clr(drop_clr), .drop_cnt(drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 1;   // 0 hold low, 1 hold high, 2 random, 3 driven by test
  logic [W:0] exp_q[$];
  logic [W:0] rx_q[$];
  int rx_cyc[$];
  bit m_cap, req_prev;
  int m_len, m_cnt, accepted, drained, exp_ovf, ovf_seen;

  function automatic int lenf(int pn);
    return (pn == 0 || pn > int'(DEPTH)) ? int'(DEPTH) : pn;
  endfunction

  function automatic logic [W-1:0] lanes(int i);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < int'(CH); k++) v[k*DW +: DW] = DW'(100 * k + i);
    return v;
  endfunction

  task automatic model_flush();
    exp_q.delete(); rx_q.delete(); rx_cyc.delete();
    m_cap = 0; req_prev = 0; accepted = 0; drained = 0; m_len = 0; m_cnt = 0;
  endtask

  // One clock cycle: record handshakes, advance the frame model, step the clock
  task automatic tick();
    bit cap_now;
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
    if (out_valid && out_ready) begin
      rx_q.push_back({out_last, out_data});
      rx_cyc.push_back(cyc);
      if (out_last) drained++;
    end
    if (overflow) ovf_seen++;
    cap_now = m_cap;
    if (request && !req_prev && !cap_now) begin
      if (accepted - drained < 2) begin
        m_cap = 1; m_len = lenf(int'(point_num)); m_cnt = 0; accepted++;
      end else exp_ovf++;
    end
    req_prev = request;
    if (in_valid && cap_now) begin
      exp_q.push_back({1'(m_cnt == m_len - 1), in_data});
      m_cnt++;
      if (m_cnt == m_len) m_cap = 0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic hold_reset();
    rst = 1'b1; request = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    cyc++;
    model_flush();
  endtask

  task automatic send_frame(int pn, int n, int gap, bit pat, bit spur);
    point_num = CW'(pn); request = 1'b1; tick(); request = 1'b0;
    point_num = CW'($urandom);
    for (int i = 1; i <= n; i++) begin
      for (int g = 1; g < gap; g++) tick();
      in_valid = 1'b1;
      in_data  = pat ? lanes(i) : W'({$urandom, $urandom});
      if (spur && i == 1 && m_cap) request = 1'b1;
      tick();
      in_valid = 1'b0; request = 1'b0;
    end
  endtask

  task automatic drain(int budget);
    request = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (!m_cap && rx_q.size() >= exp_q.size() && !out_valid) break;
      tick();
    end
  endtask

  task automatic test_reset();
    hold_reset(); hold_reset();
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got valid=%b busy=%b exp 0 0", out_valid, busy);
    end
  endtask

  task automatic test_basic();
    int t_last, first;
    logic [W:0] e;
    rdy_mode = 1;
    send_frame(8, 8, 5, 1, 0);
    t_last = cyc - 1;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin first = cyc; break; end
      tick();
    end
    checks++;
    if (first - t_last != 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", first - t_last); end
    drain(100);
    checks++;
    if (rx_q.size() != 8) begin errors++; $display("FAIL basic_count got %0d exp 8", rx_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_sample%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (rx_cyc.size() < 8 || rx_cyc[7] - rx_cyc[0] != 7) begin
      errors++; $display("FAIL basic_contiguous got %0d samples exp 8 in 8 cycles", rx_cyc.size());
    end else begin
      e = rx_q[7];
      for (int k = 0; k < int'(CH); k++) begin
        checks++;
        if (e[k*DW +: DW] !== DW'(100 * k + 8)) begin
          errors++; $display("FAIL basic_lane%0d got %0d exp %0d", k, e[k*DW +: DW], 100 * k + 8);
        end
      end
    end
    model_flush();
  endtask

  task automatic test_backpressure();
    logic pv, pr, pl;
    logic [W-1:0] pd;
    rdy_mode = 3; out_ready = 1'b1;
    send_frame(4, 4, 2, 1, 0);
    pv = 0; pr = 0; pl = 0; pd = '0;
    for (int k = 0; k < 60; k++) begin
      if (pv && !pr) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          errors++; $display("FAIL stall_hold got %b/%h/%b exp 1/%h/%b", out_valid, out_data, out_last, pd, pl);
        end
      end
      if (rx_q.size() == exp_q.size() && !out_valid && k > 0) break;
      out_ready = (k % 4 == 0 || k % 4 == 3);
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      tick();
    end
    checks++;
    if (rx_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", rx_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_sample%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    model_flush();
  endtask

  task automatic test_overflow();
    int base;
    logic [W:0] e;
    rdy_mode = 0;
    base = ovf_seen;
    send_frame(16, 16, 1, 0, 0);
    send_frame(16, 16, 2, 0, 1);
    point_num = CW'(16); request = 1'b1; tick(); request = 1'b0;
    tick(); tick(); tick();
    checks += 3;
    if (ovf_seen - base != 1) begin errors++; $display("FAIL ovf_pulses got %0d exp 1", ovf_seen - base); end
    if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b exp 1", busy); end
    e = exp_q[0];
    if (out_valid !== 1'b1 || out_data !== e[W-1:0]) begin
      errors++; $display("FAIL ovf_head got %b/%h exp 1/%h", out_valid, out_data, e[W-1:0]);
    end
    rdy_mode = 2;
    drain(500);
    checks++;
    if (rx_q.size() != 32) begin errors++; $display("FAIL ovf_count got %0d exp 32", rx_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_sample%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_end got %b exp 0", busy); end
    model_flush();
  endtask

  task automatic test_len_bounds();
    rdy_mode = 2;
    send_frame(0, DEPTH, 1, 0, 0);
    send_frame(DEPTH + 5, DEPTH, 1, 0, 0);
    drain(2000);
    checks++;
    if (rx_q.size() != 2 * DEPTH) begin errors++; $display("FAIL len_count got %0d exp %0d", rx_q.size(), 2 * DEPTH); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL len_sample%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    model_flush();
  endtask

  task automatic test_reset_mid();
    rdy_mode = 1;
    send_frame(8, 3, 2, 1, 0);
    hold_reset();
    checks++;
    if (out_valid !== 0 || out_last !== 0 || out_data !== '0 || busy !== 0 || overflow !== 0) begin
      errors++; $display("FAIL rst_cap got %b/%b/%h/%b/%b exp all 0", out_valid, out_last, out_data, busy, overflow);
    end
    rst = 1'b0;
    rdy_mode = 3; out_ready = 1'b1;
    send_frame(8, 8, 1, 1, 0);
    for (int k = 0; k < 20 && rx_q.size() < 5; k++) tick();
    checks++;
    if (rx_q.size() != 5) begin errors++; $display("FAIL rst_rd_reach got %0d exp 5", rx_q.size()); end
    hold_reset();
    checks++;
    if (out_valid !== 0 || out_last !== 0 || out_data !== '0 || busy !== 0 || overflow !== 0) begin
      errors++; $display("FAIL rst_rd got %b/%b/%h/%b/%b exp all 0", out_valid, out_last, out_data, busy, overflow);
    end
    rst = 1'b0;
    rdy_mode = 2;
    send_frame(8, 8, 3, 0, 0);
    drain(200);
    checks++;
    if (rx_q.size() != 8) begin errors++; $display("FAIL rst_fresh_count got %0d exp 8", rx_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_fresh%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    model_flush();
  endtask

  task automatic test_random();
    int n;
    rdy_mode = 2;
    ovf_seen = 0; exp_ovf = 0;
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(1, 24);
      send_frame(n, n, $urandom_range(1, 3), 0, 1'($urandom_range(0, 1)));
    end
    drain(3000);
    tick(); tick();
    checks += 2;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", rx_q.size(), exp_q.size()); end
    if (ovf_seen != exp_ovf) begin errors++; $display("FAIL rand_overflow got %0d exp %0d", ovf_seen, exp_ovf); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_sample%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    model_flush();
  endtask

`ifdef FRAME_RATE_BUFFER_DROP_CNT_EN
  task automatic test_drop_cnt();
    rdy_mode = 0;
    send_frame(4, 4, 1, 0, 0);
    send_frame(4, 4, 1, 0, 0);
    for (int r = 0; r < 3; r++) begin
      request = 1'b1; tick(); request = 1'b0; tick();
    end
    tick();
    checks++;
    if (drop_cnt !== 16'd3) begin errors++; $display("FAIL drop_cnt got %0d exp 3", drop_cnt); end
    drop_clr = 1'b1; tick(); drop_clr = 1'b0;
    checks++;
    if (drop_cnt !== 16'd0) begin errors++; $display("FAIL drop_clr got %0d exp 0", drop_cnt); end
    rdy_mode = 2;
    drain(200);
    checks++;
    if (rx_q.size() != 8) begin errors++; $display("FAIL drop_drain got %0d exp 8", rx_q.size()); end
    model_flush();
  endtask
`endif

  initial begin
    rst = 1'b1; request = 1'b0; in_valid = 1'b0; in_data = '0;
    point_num = '0; out_ready = 1'b0;
`ifdef FRAME_RATE_BUFFER_DROP_CNT_EN
    drop_clr = 1'b0;
`endif
    ovf_seen = 0; exp_ovf = 0;
    model_flush();
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_len_bounds();
    test_reset_mid();
    test_random();
`ifdef FRAME_RATE_BUFFER_DROP_CNT_EN
    test_drop_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

endmodule
